// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, sync pulses, display-active flag.
// Optional frame counter output enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned H_SYNC_POL = 0,
  parameter int unsigned V_SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_count
`endif
);

  // Totals are expected to fit the 10-bit counters (<= 1024).
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_DISP_W = 11'(H_DISPLAY);
  localparam logic [10:0] V_DISP_W = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic        H_POL    = 1'(H_SYNC_POL);
  localparam logic        V_POL    = 1'(V_SYNC_POL);

  logic [9:0] hpos_r, vpos_r;
  logic [9:0] h_next_s, v_next_s;
  logic       hsync_r, vsync_r, display_on_r, line_start_r, frame_start_r;
  logic       hs_act_s, vs_act_s, de_next_s;

  // Next counter position: hpos wraps at end of line and carries into vpos.
  always_comb begin
    h_next_s = hpos_r;
    v_next_s = vpos_r;
    if (hpos_r == H_LAST) begin
      h_next_s = 10'd0;
      if (vpos_r == V_LAST) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = vpos_r + 10'd1;
      end
    end else begin
      h_next_s = hpos_r + 10'd1;
      v_next_s = vpos_r;
    end
  end

  // Decode from the next position so registered syncs line up with hpos/vpos.
  always_comb begin
    hs_act_s  = ({1'b0, h_next_s} >= HS_START) && ({1'b0, h_next_s} < HS_END);
    vs_act_s  = ({1'b0, v_next_s} >= VS_START) && ({1'b0, v_next_s} < VS_END);
    de_next_s = ({1'b0, h_next_s} < H_DISP_W) && ({1'b0, v_next_s} < V_DISP_W);
  end

  // Counter and output registers; reset parks at the last pixel so the first step enters (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_r        <= H_LAST;
      vpos_r        <= V_LAST;
      hsync_r       <= ~H_POL;
      vsync_r       <= ~V_POL;
      display_on_r  <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (ce) begin
      hpos_r        <= h_next_s;
      vpos_r        <= v_next_s;
      hsync_r       <= hs_act_s ? H_POL : ~H_POL;
      vsync_r       <= vs_act_s ? V_POL : ~V_POL;
      display_on_r  <= de_next_s;
      line_start_r  <= (h_next_s == 10'd0);
      frame_start_r <= (h_next_s == 10'd0) && (v_next_s == 10'd0);
    end else begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign hpos        = hpos_r;
  assign vpos        = vpos_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign display_on  = display_on_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_count_r;

  // Frame counter counts completed frame_start pulses, wrapping naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_r <= 8'd0;
    end else if (frame_start_r) begin
      frame_count_r <= frame_count_r + 8'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  assign frame_count = frame_count_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole frames fit the run.
// A raster-index reference model predicts outputs; a monitor compares after each edge.
module tb_vga_timing_gen;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int TOT = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [9:0] hpos, vpos;
  logic       hsync, vsync, display_on, line_start, frame_start;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_count;
`endif

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(0), .V_SYNC_POL(0)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v;
    bit hs; bit vs; bit de; bit ls; bit fs;
    int fc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model state: linear raster index plus frame count.
  int  t = TOT - 1;
  bit  fs_prev = 1'b0;
  int  fc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive inputs and push the predicted post-edge outputs.
  task automatic step(input bit r, input bit c);
    exp_t e;
    @(negedge clk);
    reset = r;
    ce = c;
    if (r) begin
      t = TOT - 1; fc = 0;
      e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      if (fs_prev) fc = (fc + 1) % 256;
      if (c) begin
        t = (t + 1) % TOT;
        e.ls = ((t % HT) == 0);
        e.fs = (t == 0);
      end else begin
        e.ls = 1'b0; e.fs = 1'b0;
      end
    end
    fs_prev = e.fs;
    e.h = t % HT;
    e.v = t / HT;
    e.hs = !(e.h >= HD + HF && e.h < HD + HF + HS);
    e.vs = !(e.v >= VD + VF && e.v < VD + VF + VS);
    e.de = (e.h < HD) && (e.v < VD);
    if (r) begin
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
    end
    e.fc = fc;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after every edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hpos", 32'(hpos), 32'(e.h));
      chk("vpos", 32'(vpos), 32'(e.v));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("display_on", 32'(display_on), 32'(e.de));
      chk("line_start", 32'(line_start), 32'(e.ls));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
`ifdef VGA_FRAME_COUNTER_EN
      chk("frame_count", 32'(frame_count), 32'(e.fc));
`endif
    end
  end

  initial begin
    int frames;
    // Reset held with ce randomised: reset must win.
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
    // Release into (0,0), advance to hpos=10, then ce pattern 1,0,0,1.
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    // Run into the hsync window, reset mid-pulse, then release.
    for (int i = 0; i < 3 * HT && (t % HT) != HD + HF + 1; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    // Randomised ce with rare resets.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0);
    // Clean run from reset across many frames (covers 8-bit frame counter wrap).
    step(1'b1, 1'b0);
`ifdef VGA_FRAME_COUNTER_EN
    frames = 258;
`else
    frames = 4;
`endif
    for (int i = 0; i < frames * TOT + 2 * HT; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #5;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: horizontal/vertical counters, sync pulses and display-active flag.
- Sits directly upstream of the tt_um_vga_example_piao pixel logic, which consumes hpos/vpos/display_on to compute RGB.
- The top level drives reset from ~rst_n and routes hsync/vsync to uo_out.
- Default timing is 640x480 @ 60 Hz with a 25.175 MHz pixel rate (ce tied high when clk equals the pixel clock).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync (0 = active-low)

Ports:
- clk  input  1  pixel-domain clock
- reset  input  1  synchronous, active-high reset
- ce  input  1  pixel advance enable; counters step only on clk edges with ce=1
- hpos  output  10  current horizontal position, 0..H_TOTAL-1
- vpos  output  10  current vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per H_SYNC_POL
- vsync  output  1  vertical sync, polarity per V_SYNC_POL
- display_on  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  output  1  one-clk pulse on entry to hpos=0
- frame_start  output  1  one-clk pulse on entry to (hpos=0, vpos=0)

Behaviour:
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 by default).
  - Both totals must be ≤1024.
- Reset (synchronous, wins over ce):
  - hpos=H_TOTAL-1 (799), vpos=V_TOTAL-1 (524).
  - hsync and vsync at inactive level; display_on=0; line_start=0; frame_start=0.
  - The first ce edge after reset therefore enters (0,0) and pulses frame_start and line_start.
- Advance on clk edge with ce=1 and reset=0:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps V_TOTAL-1 -> 0 only when hpos also wraps.
- ce=0: hpos, vpos, hsync, vsync and display_on hold; line_start and frame_start drive 0.
- All outputs are registered.
  - hsync, vsync and display_on are decoded from next-state counter values, so they correspond to the hpos/vpos presented in the same cycle (zero skew, no extra latency).
- hsync active when H_DISPLAY+H_FRONT ≤ hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync active when V_DISPLAY+V_FRONT ≤ vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491). vsync changes only at the hpos wrap.
- line_start=1 for exactly one clk after an advance into hpos=0.
- frame_start=1 for exactly one clk after an advance into hpos=0, vpos=0; it coincides with line_start.
- Reset mid-frame: the next clk applies reset values regardless of position or ce. No partial sync pulse is extended.
- No other state; no handshake stalls. The block never back-pressures.

Optional Feature:
- Macro VGA_FRAME_COUNTER_EN.
- Defined:
  - Adds output port frame_count [7:0].
  - Reset value 0; increments by 1 on each clk where frame_start=1; wraps 255 -> 0.
  - Used by downstream pixel logic for animation.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then release with ce=1:
  - During reset: hpos=799, vpos=524, hsync=1, vsync=1, display_on=0.
  - First clk after release: hpos=0, vpos=0, display_on=1, frame_start=1, line_start=1.
  - Second clk: both pulses 0.
- One full line, ce=1:
  - display_on=1 at hpos 639, 0 at hpos 640.
  - hsync=0 exactly for hpos 656..751 (96 clks).
  - line_start pulses once every 800 clks.
- One full frame:
  - vsync=0 for vpos 490..491 (1600 clks).
  - display_on=0 for all vpos ≥480.
  - frame_start interval = 420000 clks.
- ce toggling 1,0,0,1 at hpos=10: hpos reads 11,11,11,12; hsync/vsync/display_on stable while ce=0; no pulses while stalled.
- Reset asserted at hpos=700 (inside hsync): next clk hpos=799, vpos=524, hsync=1; re-release yields frame_start on the following clk.
- VGA_FRAME_COUNTER_EN defined, run 257 frames: frame_count goes 0 after reset, 1 after first frame_start, ..., 255, then 0, then 1.
